// File: rtl/dlx_pkg.sv
// Shared DLX pipeline definitions: PC step, NOP encoding and fetch FSM states.
package dlx_pkg;

  localparam int unsigned PC_INCREMENT = 32'd4;
  localparam logic [31:0] DLX_NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_pipe.sv
// IF/ID pipeline register plus a one-entry skid buffer for words that arrive
// while decode is stalled.
module instruction_fetch_pipe #(
  parameter int unsigned                  PC_WIDTH          = 32,
  parameter int unsigned                  INSTRUCTION_WIDTH = 32,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION   = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         load,
  input  logic                         skid_capture,
  input  logic                         skid_release,
  input  logic                         bubble,
  input  logic [INSTRUCTION_WIDTH-1:0] data,
  input  logic [PC_WIDTH-1:0]          next_pc,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]          new_pc,
  output logic                         valid
);

  logic [INSTRUCTION_WIDTH-1:0] ins_r;
  logic [PC_WIDTH-1:0]          npc_r;
  logic                         vld_r;
  logic [INSTRUCTION_WIDTH-1:0] skid_ins_r;
  logic [PC_WIDTH-1:0]          skid_pc_r;
  logic                         skid_vld_r;

  // IF/ID and skid update; flush dominates, otherwise the controls are exclusive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_r      <= NOP_INSTRUCTION;
      npc_r      <= {PC_WIDTH{1'b0}};
      vld_r      <= 1'b0;
      skid_ins_r <= NOP_INSTRUCTION;
      skid_pc_r  <= {PC_WIDTH{1'b0}};
      skid_vld_r <= 1'b0;
    end else if (flush) begin
      ins_r      <= NOP_INSTRUCTION;
      npc_r      <= {PC_WIDTH{1'b0}};
      vld_r      <= 1'b0;
      skid_vld_r <= 1'b0;
    end else if (load) begin
      ins_r <= data;
      npc_r <= next_pc;
      vld_r <= 1'b1;
    end else if (skid_capture) begin
      skid_ins_r <= data;
      skid_pc_r  <= next_pc;
      skid_vld_r <= 1'b1;
    end else if (skid_release) begin
      ins_r      <= skid_ins_r;
      npc_r      <= skid_pc_r;
      vld_r      <= skid_vld_r;
      skid_vld_r <= 1'b0;
    end else if (bubble) begin
      vld_r <= 1'b0;
    end else begin
      vld_r <= vld_r;
    end
  end

  assign instruction = ins_r;
  assign new_pc      = npc_r;
  assign valid       = vld_r;

endmodule

// File: rtl/instruction_fetch.sv
// DLX instruction fetch stage: PC, fetch FSM and imem req/ack handshake,
// feeding the IF/ID register in instruction_fetch_pipe.
module instruction_fetch
  import dlx_pkg::*;
#(
  parameter int unsigned                  PC_WIDTH          = 32,
  parameter int unsigned                  INSTRUCTION_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]          RESET_PC          = 32'h0000_0000,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTRUCTION   = DLX_NOP
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall_in,
  input  logic                         branch_taken_in,
  input  logic [PC_WIDTH-1:0]          branch_target_in,
  output logic                         imem_req_out,
  output logic [PC_WIDTH-1:0]          imem_addr_out,
  input  logic                         imem_ack_in,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_data_in,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_reg_out,
  output logic [PC_WIDTH-1:0]          new_pc_out,
  output logic                         inst_valid_out
);

  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

  fetch_state_e        state_r, state_s;
  logic [PC_WIDTH-1:0] pc_r, pc_s, target_r, target_s;
  logic [PC_WIDTH-1:0] pc_inc_s, branch_pc_s;
  logic                flush_s, load_s, capture_s, release_s, bubble_s;

  assign pc_inc_s    = pc_r + PC_WIDTH'(PC_INCREMENT);
  assign branch_pc_s = branch_target_in & ALIGN_MASK;

  // State, PC and pending redirect target registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= BOOT;
      pc_r     <= RESET_PC & ALIGN_MASK;
      target_r <= RESET_PC & ALIGN_MASK;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      target_r <= target_s;
    end
  end

  // Next-state, PC update and IF/ID control decode; redirect outranks stall and ack
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    target_s  = target_r;
    flush_s   = 1'b0;
    load_s    = 1'b0;
    capture_s = 1'b0;
    release_s = 1'b0;
    bubble_s  = 1'b0;
    case (state_r)
      BOOT: begin
        flush_s = branch_taken_in;
        pc_s    = branch_taken_in ? branch_pc_s : pc_r;
        state_s = FETCH;
      end
      FETCH: begin
        if (branch_taken_in) begin
          flush_s = 1'b1;
          if (imem_ack_in) begin
            pc_s = branch_pc_s;
          end else begin
            // address must stay put until the outstanding request completes
            target_s = branch_pc_s;
            state_s  = DISCARD;
          end
        end else if (imem_ack_in) begin
          pc_s = pc_inc_s;
          if (stall_in) begin
            capture_s = 1'b1;
            state_s   = HOLD;
          end else begin
            load_s = 1'b1;
          end
        end else begin
          bubble_s = ~stall_in;
        end
      end
      HOLD: begin
        if (branch_taken_in) begin
          flush_s = 1'b1;
          pc_s    = branch_pc_s;
          state_s = FETCH;
        end else if (!stall_in) begin
          release_s = 1'b1;
          state_s   = FETCH;
        end else begin
          state_s = HOLD;
        end
      end
      DISCARD: begin
        flush_s = branch_taken_in;
        if (imem_ack_in) begin
          pc_s    = branch_taken_in ? branch_pc_s : target_r;
          state_s = FETCH;
        end else begin
          target_s = branch_taken_in ? branch_pc_s : target_r;
        end
      end
      default: begin
        state_s = BOOT;
        pc_s    = RESET_PC & ALIGN_MASK;
      end
    endcase
  end

  assign imem_req_out  = (state_r == FETCH) || (state_r == DISCARD);
  assign imem_addr_out = pc_r & ALIGN_MASK;

  instruction_fetch_pipe #(
    .PC_WIDTH          (PC_WIDTH),
    .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
    .NOP_INSTRUCTION   (NOP_INSTRUCTION)
  ) u_pipe (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush_s),
    .load         (load_s),
    .skid_capture (capture_s),
    .skid_release (release_s),
    .bubble       (bubble_s),
    .data         (imem_data_in),
    .next_pc      (pc_inc_s),
    .instruction  (instruction_reg_out),
    .new_pc       (new_pc_out),
    .valid        (inst_valid_out)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, a reset
// sequence, then randomized traffic against a transaction-level model.
module tb_instruction_fetch;
  import dlx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br;
  logic [31:0] tgt;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;
  logic [31:0] ins;
  logic [31:0] npc;
  logic        vld;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .stall_in            (stall),
    .branch_taken_in     (br),
    .branch_target_in    (tgt),
    .imem_req_out        (req),
    .imem_addr_out       (addr),
    .imem_ack_in         (ack),
    .imem_data_in        (data),
    .instruction_reg_out (ins),
    .new_pc_out          (npc),
    .inst_valid_out      (vld)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] e_ins;
    logic [31:0] e_npc;
    logic        e_vld;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] npc;
  } skid_t;

  vec_t tbl[30];

  // reference model state (transaction view: booting flag, pending-redirect flag, skid queue)
  logic [31:0] m_pc, m_ins, m_npc, m_tgt;
  logic        m_vld;
  bit          m_boot, m_disc;
  skid_t       skid_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] ei, input logic [31:0] en,
                           input logic ev, input logic er, input logic [31:0] ea);
    check($sformatf("%s.instr", tag), ins, ei);
    check($sformatf("%s.new_pc", tag), npc, en);
    check($sformatf("%s.valid", tag), {31'd0, vld}, {31'd0, ev});
    check($sformatf("%s.req", tag), {31'd0, req}, {31'd0, er});
    check($sformatf("%s.addr", tag), addr, ea);
  endtask

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t, input logic a,
                              input logic [31:0] ei, input logic [31:0] en, input logic ev,
                              input logic er, input logic [31:0] ea);
    vec_t v;
    v.stall = s; v.br = b; v.tgt = t; v.ack = a;
    v.e_ins = ei; v.e_npc = en; v.e_vld = ev; v.e_req = er; v.e_addr = ea;
    return v;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ins = DLX_NOP; m_npc = 32'h0; m_vld = 1'b0; m_tgt = 32'h0;
    m_boot = 1'b1; m_disc = 1'b0;
    skid_q.delete();
  endtask

  function automatic logic model_req();
    return !m_boot && (skid_q.size() == 0);
  endfunction

  task automatic model_step(input logic s, input logic b, input logic [31:0] t,
                            input logic a, input logic [31:0] d);
    logic  requesting;
    skid_t e;
    requesting = model_req();
    if (b) begin
      m_ins = DLX_NOP; m_npc = 32'h0; m_vld = 1'b0;
      skid_q.delete();
      if (!requesting) begin
        m_pc = t & 32'hFFFF_FFFC; m_boot = 1'b0;
      end else if (a) begin
        m_pc = t & 32'hFFFF_FFFC; m_disc = 1'b0;
      end else begin
        m_disc = 1'b1; m_tgt = t & 32'hFFFF_FFFC;
      end
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (skid_q.size() != 0) begin
      if (!s) begin
        e = skid_q.pop_front();
        m_ins = e.ins; m_npc = e.npc; m_vld = 1'b1;
      end
    end else if (m_disc) begin
      if (a) begin
        m_pc = m_tgt; m_disc = 1'b0;
      end
    end else if (a) begin
      if (s) begin
        e.ins = d; e.npc = m_pc + 32'd4;
        skid_q.push_back(e);
      end else begin
        m_ins = d; m_npc = m_pc + 32'd4; m_vld = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!s) begin
      m_vld = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] key;
    int          wait_cnt;
    int          cur_lat;
    logic        req_before;

    // zero-latency walk, 2-cycle ack, stall/skid, redirects, stall+branch, wrap, redirect in HOLD and DISCARD
    tbl[0]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    tbl[1]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h0, 32'h4, 1'b1, 1'b1, 32'h4);
    tbl[2]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h4, 32'h8, 1'b1, 1'b1, 32'h8);
    tbl[3]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h8, 32'hC, 1'b1, 1'b1, 32'hC);
    tbl[4]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h8, 32'hC, 1'b0, 1'b1, 32'hC);
    tbl[5]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h8, 32'hC, 1'b0, 1'b1, 32'hC);
    tbl[6]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'hC, 32'h10, 1'b1, 1'b1, 32'h10);
    tbl[7]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'hC, 32'h10, 1'b1, 1'b0, 32'h14);
    tbl[8]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'hC, 32'h10, 1'b1, 1'b0, 32'h14);
    tbl[9]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'hC, 32'h10, 1'b1, 1'b0, 32'h14);
    tbl[10] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h10, 32'h14, 1'b1, 1'b1, 32'h14);
    tbl[11] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h14, 32'h18, 1'b1, 1'b1, 32'h18);
    tbl[12] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h14, 32'h18, 1'b0, 1'b1, 32'h18);
    tbl[13] = mk(1'b0, 1'b1, 32'h103, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h18);
    tbl[14] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h100);
    tbl[15] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h104, 1'b1, 1'b1, 32'h104);
    tbl[16] = mk(1'b1, 1'b1, 32'h200, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h200);
    tbl[17] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h204);
    tbl[18] = mk(1'b1, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h204);
    tbl[19] = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h200, 32'h204, 1'b1, 1'b1, 32'h204);
    tbl[20] = mk(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tbl[21] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1, 32'h0);
    tbl[22] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h0, 32'h4, 1'b1, 1'b1, 32'h4);
    tbl[23] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h0, 32'h4, 1'b1, 1'b0, 32'h8);
    tbl[24] = mk(1'b1, 1'b1, 32'h40,  1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h40);
    tbl[25] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h40, 32'h44, 1'b1, 1'b1, 32'h44);
    tbl[26] = mk(1'b0, 1'b1, 32'h80,  1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h44);
    tbl[27] = mk(1'b0, 1'b1, 32'h90,  1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h44);
    tbl[28] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h0, 32'h0, 1'b0, 1'b1, 32'h90);
    tbl[29] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h90, 32'h94, 1'b1, 1'b1, 32'h94);

    rst_n = 1'b0; stall = 1'b0; br = 1'b0; tgt = 32'h0; ack = 1'b0; data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", DLX_NOP, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      stall = tbl[i].stall; br = tbl[i].br; tgt = tbl[i].tgt; ack = tbl[i].ack;
      data  = tbl[i].ack ? addr : 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), tbl[i].e_ins, tbl[i].e_npc, tbl[i].e_vld,
                tbl[i].e_req, tbl[i].e_addr);
    end

    // asynchronous reset mid-request, then a stray ack during BOOT
    stall = 1'b0; br = 1'b0; ack = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", DLX_NOP, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; ack = 1'b1; data = 32'hBAD0_BAD0;
    @(posedge clk);
    #1;
    check_all("boot_ack", DLX_NOP, 32'h0, 1'b0, 1'b1, 32'h0);
    data = 32'h1234_5678;
    @(posedge clk);
    #1;
    check_all("restart", 32'h1234_5678, 32'h4, 1'b1, 1'b1, 32'h4);

    // randomized traffic against the model
    ack = 1'b0; rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    key = $urandom;
    wait_cnt = 0;
    cur_lat = 1;
    for (int c = 0; c < 3000; c++) begin
      stall = ($urandom_range(0, 9) < 3);
      br    = ($urandom_range(0, 19) == 0);
      tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      req_before = req;
      ack   = req && (wait_cnt >= cur_lat);
      data  = ack ? (addr ^ key) : $urandom;
      model_step(stall, br, tgt, ack, data);
      @(posedge clk);
      #1;
      if (ack) begin
        wait_cnt = 0;
        cur_lat  = $urandom_range(0, 2);
      end else if (req_before) begin
        wait_cnt++;
      end
      check_all($sformatf("rand%0d", c), m_ins, m_npc, m_vld, model_req(), m_pc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- DLX instruction fetch (IF) stage. Holds the program counter and requests instruction words from instruction memory over a req/ack handshake.
- Registers each fetched instruction and its PC+4 into the IF/ID pipeline register. That register directly drives the decode stage inputs instruction_reg_in and new_pc_in.
- Accepts the decode-stall backpressure and the branch/jump redirect coming back from later stages.

Parameters:
- PC_WIDTH, 32, program counter / instruction address width
- INSTRUCTION_WIDTH, 32, instruction word width
- RESET_PC, 0, first fetch address after reset (bits [1:0] must be 0)
- NOP_INSTRUCTION, 32'h0000_0000, word loaded into the IF/ID register on reset and flush

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_in  in  1  decode cannot accept a new instruction; hold the IF/ID register
- branch_taken_in  in  1  redirect request from a branch/jump, single-cycle pulse
- branch_target_in  in  PC_WIDTH  redirect address; bits [1:0] ignored
- imem_req_out  out  1  instruction memory request
- imem_addr_out  out  PC_WIDTH  word-aligned fetch address; stable while req high and no ack
- imem_ack_in  in  1  memory response; imem_data_in valid in this cycle; may be asserted in the same cycle as req
- imem_data_in  in  INSTRUCTION_WIDTH  fetched instruction word
- instruction_reg_out  out  INSTRUCTION_WIDTH  IF/ID instruction, to decode instruction_reg_in
- new_pc_out  out  PC_WIDTH  PC+4 of instruction_reg_out, to decode new_pc_in
- inst_valid_out  out  1  IF/ID register holds a real instruction (0 = bubble)

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=BOOT, imem_req_out=0, imem_addr_out=RESET_PC
  - instruction_reg_out=NOP_INSTRUCTION, new_pc_out=0, inst_valid_out=0, skid buffer cleared
- imem_addr_out = {pc[PC_WIDTH-1:2],2'b00}. pc+4 wraps modulo 2^PC_WIDTH; no overflow flag.
- States:
  - BOOT: one cycle after reset release with req=0; then -> FETCH.
  - FETCH: req=1.
    - ack & !stall: IF/ID <= {imem_data_in, pc+4, valid=1}, pc<=pc+4, stay in FETCH (back-to-back requests, 1 instr/cycle).
    - ack & stall: skid <= {data, pc+4}, pc<=pc+4, -> HOLD.
    - !ack: IF/ID unchanged if stall; if !stall, inst_valid_out<=0 (bubble).
  - HOLD: req=0; IF/ID held. When !stall: IF/ID <= skid with valid=1, -> FETCH.
  - DISCARD: req=1 with the old address until ack; the returned data is dropped; then pc=saved target, -> FETCH.
- Latency: zero-wait memory means a request accepted in cycle N appears on the IF/ID outputs in cycle N+1.
- branch_taken_in has highest priority, overriding both stall and ack:
  - IF/ID <= {NOP_INSTRUCTION, 0, valid=0}; skid invalidated.
  - In FETCH with ack in the same cycle: pc<=target aligned, stay in FETCH; the next request uses the target.
  - In FETCH with no ack: target saved, -> DISCARD (the memory contract forbids changing the address mid-request).
  - In HOLD or BOOT: pc<=target, -> FETCH.
  - In DISCARD: the saved target is overwritten (last redirect wins).
- Simultaneous stall & branch: the flush occurs. The bubble (valid=0) is held while stall persists.
- Reset asserted mid-request: everything returns to reset values immediately. A late ack while in BOOT is ignored.
- No combinational path from stall_in or branch_taken_in to imem_req_out/imem_addr_out, except that req follows the state register.

Decomposition:
- Shared package dlx_pkg:
  - PC_INCREMENT=4
  - NOP_INSTRUCTION encoding
  - fetch state encoding (BOOT, FETCH, HOLD, DISCARD)
- Sub-module instruction_fetch_pipe: the IF/ID register plus the one-entry skid buffer, with load/hold/flush controls. It mirrors inst_decode_pipe on the decode side.
- PC and FSM stay in instruction_fetch.

Test Plan:
- Reset, then a zero-wait memory returning word = address -> req high from cycle 2. Outputs (0x0,0x4,1), (0x4,0x8,1), (0x8,0xC,1) in consecutive cycles.
- Memory with 2-cycle ack latency -> imem_addr_out stable for 3 cycles. inst_valid_out=0 between instructions. new_pc_out correct.
- stall_in high for 3 cycles while an ack arrives -> IF/ID holds the previous instruction. Skid captured, req low. On release the skid word appears with valid=1 and no instruction is lost or duplicated.
- branch_taken_in with target 0x103 during an outstanding 2-cycle request -> valid drops to 0 and the old data is discarded. The next imem_addr_out is 0x100. The first valid output is (mem[0x100], 0x104).
- Branch and stall in the same cycle -> IF/ID = NOP, valid=0, held through the stall. Fetch resumes at the target.
- rst_n pulsed low mid-request -> all outputs return to reset values asynchronously. An ack arriving during BOOT is ignored. Fetch restarts at RESET_PC; also check pc 0xFFFFFFFC wraps to 0x0.
